// File: rtl/store_drain_buffer.sv
// Retire-side store buffer: queues committed stores, drains them in order to the
// data-memory bus, and answers store-to-load forwarding probes from the load unit.
module store_drain_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      st_command,
    input  logic [1:0]      st_size,
    input  logic [XLEN-1:0] st_addr,
    input  logic [XLEN-1:0] st_data,
    input  logic            bus_busy,
    input  logic [3:0]      mem2proc_response,
    input  logic [XLEN-1:0] ld_addr,
    input  logic            ld_valid,
    output logic [1:0]      proc2Dmem_command,
    output logic [1:0]      proc2Dmem_size,
    output logic [XLEN-1:0] proc2Dmem_addr,
    output logic [XLEN-1:0] proc2Dmem_data,
    output logic            ld_fwd_hit,
    output logic [XLEN-1:0] ld_fwd_data,
    output logic            ld_conflict,
    output logic            sb_full,
    output logic            sb_empty,
    output logic            sb_overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam logic [1:0] SZ_BYTE   = 2'd0;
    localparam logic [1:0] SZ_WORD   = 2'd2;

    logic [1:0]      ent_size [DEPTH];
    logic [XLEN-1:0] ent_addr [DEPTH];
    logic [XLEN-1:0] ent_data [DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    logic issue, deq, enq_req, enq_ok;

    assign issue   = (count != '0) && !bus_busy;
    assign deq     = issue && (mem2proc_response != 4'd0);
    assign enq_req = (st_command == BUS_STORE);
    // A full buffer can still take a store when the head leaves on the same edge.
    assign enq_ok  = enq_req && ((count != CNT_W'(DEPTH)) || deq);

    always_ff @(posedge clock) begin
        if (!reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            sb_overflow <= 1'b0;
        end else begin
            if (enq_ok) begin
                tail <= tail + 1'b1;
            end else if (enq_req) begin
                sb_overflow <= 1'b1;
            end
            if (deq) begin
                head <= head + 1'b1;
            end
            if (enq_ok && !deq) begin
                count <= count + 1'b1;
            end else if (deq && !enq_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (enq_ok) begin
            ent_size[tail] <= st_size;
            ent_addr[tail] <= st_addr;
            ent_data[tail] <= st_data;
        end
    end

    always_comb begin
        proc2Dmem_command = BUS_NONE;
        proc2Dmem_size    = SZ_BYTE;
        proc2Dmem_addr    = '0;
        proc2Dmem_data    = '0;
        if (issue) begin
            proc2Dmem_command = BUS_STORE;
            proc2Dmem_size    = ent_size[head];
            proc2Dmem_addr    = ent_addr[head];
            proc2Dmem_data    = ent_data[head];
        end
    end

    logic             match;
    logic [1:0]       match_size;
    logic [XLEN-1:0]  match_data;
    logic [PTR_W-1:0] idx;

    // Scan oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        match      = 1'b0;
        match_size = SZ_BYTE;
        match_data = '0;
        idx        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (ent_addr[idx][XLEN-1:2] == ld_addr[XLEN-1:2])) begin
                match      = 1'b1;
                match_size = ent_size[idx];
                match_data = ent_data[idx];
            end
        end
    end

    always_comb begin
        ld_fwd_hit  = 1'b0;
        ld_conflict = 1'b0;
        ld_fwd_data = '0;
        if (ld_valid && match) begin
            if ((match_size == SZ_WORD) && (ld_addr[1:0] == 2'b00)) begin
                ld_fwd_hit  = 1'b1;
                ld_fwd_data = match_data;
            end else begin
                ld_conflict = 1'b1;
            end
        end
    end

    assign sb_full  = (count == CNT_W'(DEPTH));
    assign sb_empty = (count == '0);

endmodule

// File: tb/tb_store_drain_buffer.sv
// Bench for store_drain_buffer: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_store_drain_buffer;
    localparam int DEPTH = 4;
    localparam logic [1:0] NONE = 2'd0, STORE = 2'd2;
    localparam logic [1:0] BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  st_command, st_size;
    logic [31:0] st_addr, st_data;
    logic        bus_busy;
    logic [3:0]  mem2proc_response;
    logic [31:0] ld_addr;
    logic        ld_valid;
    logic [1:0]  proc2Dmem_command, proc2Dmem_size;
    logic [31:0] proc2Dmem_addr, proc2Dmem_data;
    logic        ld_fwd_hit, ld_conflict, sb_full, sb_empty, sb_overflow;
    logic [31:0] ld_fwd_data;

    int tests = 0;
    int failed = 0;
    bit cmp_en = 1'b0;

    store_drain_buffer #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clock(clock), .reset(reset),
        .st_command(st_command), .st_size(st_size), .st_addr(st_addr), .st_data(st_data),
        .bus_busy(bus_busy), .mem2proc_response(mem2proc_response),
        .ld_addr(ld_addr), .ld_valid(ld_valid),
        .proc2Dmem_command(proc2Dmem_command), .proc2Dmem_size(proc2Dmem_size),
        .proc2Dmem_addr(proc2Dmem_addr), .proc2Dmem_data(proc2Dmem_data),
        .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data), .ld_conflict(ld_conflict),
        .sb_full(sb_full), .sb_empty(sb_empty), .sb_overflow(sb_overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is a plain queue of committed stores.
    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;
    ent_t q[$];
    bit   m_ovf = 1'b0;

    always @(posedge clock) begin
        bit do_deq;
        ent_t e;
        if (!reset) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            do_deq = (q.size() != 0) && !bus_busy && (mem2proc_response != 4'd0);
            if (do_deq) void'(q.pop_front());
            if (st_command == STORE) begin
                if (q.size() < DEPTH) begin
                    e.size = st_size; e.addr = st_addr; e.data = st_data;
                    q.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        logic [1:0]  e_cmd, e_size;
        logic [31:0] e_addr, e_data, e_fdata;
        logic        e_hit, e_conf;
        if (cmp_en) begin
            e_cmd = NONE; e_size = BYTE; e_addr = '0; e_data = '0;
            if (q.size() != 0 && !bus_busy) begin
                e_cmd = STORE; e_size = q[0].size; e_addr = q[0].addr; e_data = q[0].data;
            end
            e_hit = 1'b0; e_conf = 1'b0; e_fdata = '0;
            if (ld_valid) begin
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (q[i].addr[31:2] == ld_addr[31:2]) begin
                        if (q[i].size == WORD && ld_addr[1:0] == 2'b00) begin
                            e_hit = 1'b1; e_fdata = q[i].data;
                        end else begin
                            e_conf = 1'b1;
                        end
                        break;
                    end
                end
            end
            check("m_cmd", 32'(proc2Dmem_command), 32'(e_cmd));
            check("m_size", 32'(proc2Dmem_size), 32'(e_size));
            check("m_addr", proc2Dmem_addr, e_addr);
            check("m_data", proc2Dmem_data, e_data);
            check("m_hit", 32'(ld_fwd_hit), 32'(e_hit));
            check("m_fdata", ld_fwd_data, e_fdata);
            check("m_conflict", 32'(ld_conflict), 32'(e_conf));
            check("m_full", 32'(sb_full), 32'(q.size() == DEPTH));
            check("m_empty", 32'(sb_empty), 32'(q.size() == 0));
            check("m_ovf", 32'(sb_overflow), 32'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        st_command = NONE; st_size = BYTE; st_addr = '0; st_data = '0;
        bus_busy = 1'b0; mem2proc_response = 4'd0; ld_addr = '0; ld_valid = 1'b0;
    endtask

    task automatic enq(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        st_command = STORE; st_size = sz; st_addr = a; st_data = d;
    endtask

    task automatic no_enq();
        st_command = NONE; st_size = BYTE; st_addr = '0; st_data = '0;
    endtask

    initial begin
        idle();
        // T1 reset
        reset = 1'b0;
        tick(); tick();
        #1;
        check("t1_cmd", 32'(proc2Dmem_command), 32'(NONE));
        check("t1_empty", 32'(sb_empty), 32'd1);
        check("t1_full", 32'(sb_full), 32'd0);
        check("t1_ovf", 32'(sb_overflow), 32'd0);
        cmp_en = 1'b1;
        reset = 1'b1;

        // T2 single store
        enq(WORD, 32'h100, 32'hDEADBEEF);
        tick();
        no_enq(); mem2proc_response = 4'd1;
        #1;
        check("t2_cmd", 32'(proc2Dmem_command), 32'(STORE));
        check("t2_addr", proc2Dmem_addr, 32'h100);
        check("t2_data", proc2Dmem_data, 32'hDEADBEEF);
        check("t2_size", 32'(proc2Dmem_size), 32'(WORD));
        tick();
        #1;
        check("t2_empty", 32'(sb_empty), 32'd1);
        check("t2_idle", 32'(proc2Dmem_command), 32'(NONE));

        // T3 backpressure, overflow, in-order drain
        bus_busy = 1'b1; mem2proc_response = 4'd0;
        for (int k = 0; k < 4; k++) begin
            enq(WORD, 32'h300 + 32'(4 * k), 32'(k + 1));
            tick();
        end
        #1;
        check("t3_full", 32'(sb_full), 32'd1);
        check("t3_noovf", 32'(sb_overflow), 32'd0);
        enq(WORD, 32'h3F0, 32'hBAD);
        tick();
        #1;
        check("t3_ovf", 32'(sb_overflow), 32'd1);
        no_enq(); bus_busy = 1'b0; mem2proc_response = 4'd1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t3_order_addr", proc2Dmem_addr, 32'h300 + 32'(4 * k));
            check("t3_order_data", proc2Dmem_data, 32'(k + 1));
            tick();
        end
        #1;
        check("t3_empty", 32'(sb_empty), 32'd1);

        // T4 retry
        mem2proc_response = 4'd0;
        enq(WORD, 32'h400, 32'h44);
        tick();
        no_enq();
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t4_hold_addr", proc2Dmem_addr, 32'h400);
            check("t4_hold_data", proc2Dmem_data, 32'h44);
            tick();
        end
        mem2proc_response = 4'd2;
        #1;
        check("t4_last_addr", proc2Dmem_addr, 32'h400);
        tick();
        #1;
        check("t4_empty", 32'(sb_empty), 32'd1);

        // T5 forwarding (fresh reset clears sticky overflow)
        idle();
        reset = 1'b0; tick(); reset = 1'b1;
        bus_busy = 1'b1;
        enq(WORD, 32'h200, 32'h11); tick();
        enq(WORD, 32'h200, 32'h22); tick();
        no_enq(); ld_valid = 1'b1; ld_addr = 32'h200;
        #1;
        check("t5_hit", 32'(ld_fwd_hit), 32'd1);
        check("t5_fdata", ld_fwd_data, 32'h22);
        check("t5_noconf", 32'(ld_conflict), 32'd0);
        enq(BYTE, 32'h203, 32'h33); tick();
        no_enq();
        #1;
        check("t5_conf", 32'(ld_conflict), 32'd1);
        check("t5_conf_nohit", 32'(ld_fwd_hit), 32'd0);
        ld_addr = 32'h204;
        #1;
        check("t5_miss_hit", 32'(ld_fwd_hit), 32'd0);
        check("t5_miss_conf", 32'(ld_conflict), 32'd0);
        ld_valid = 1'b0;

        // T6 full + simultaneous enq/deq, then reset mid-drain
        enq(WORD, 32'h240, 32'h44); tick();
        #1;
        check("t6_full", 32'(sb_full), 32'd1);
        bus_busy = 1'b0; mem2proc_response = 4'd1;
        enq(WORD, 32'h500, 32'h55);
        #1;
        check("t6_head", proc2Dmem_addr, 32'h200);
        tick();
        no_enq(); mem2proc_response = 4'd0;
        #1;
        check("t6_still_full", 32'(sb_full), 32'd1);
        check("t6_noovf", 32'(sb_overflow), 32'd0);
        check("t6_next_head", proc2Dmem_data, 32'h22);
        reset = 1'b0;
        tick();
        #1;
        check("t6_rst_empty", 32'(sb_empty), 32'd1);
        check("t6_rst_cmd", 32'(proc2Dmem_command), 32'(NONE));
        reset = 1'b1;

        // Randomized traffic, addresses clustered so forwarding paths get exercised
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) != 0);
            st_command = ($urandom_range(0, 9) < 5) ? STORE : 2'($urandom_range(0, 1));
            st_size = 2'($urandom_range(0, 2));
            st_addr = 32'h600 + 32'($urandom_range(0, 15));
            st_data = $urandom;
            bus_busy = ($urandom_range(0, 9) < 3);
            mem2proc_response = ($urandom_range(0, 9) < 6) ? 4'($urandom_range(1, 15)) : 4'd0;
            ld_valid = $urandom_range(0, 1) == 1;
            ld_addr = 32'h600 + 32'($urandom_range(0, 19));
            tick();
        end

        idle();
        tick();
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
